// File: rtl/keypad_emulator_if.sv
// Keystroke command port of the keypad emulator.
// The host (master) offers a key position; the emulator (slave) accepts it.
interface keypad_emulator_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_pos;

    modport master (
        output cmd_valid,
        output cmd_pos,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_pos,
        output cmd_ready
    );
endinterface

// File: rtl/keypad_emulator.sv
// Virtual 4x4 matrix keypad: answers scanner column strobes on the row lines,
// replaying queued keystrokes with a fixed hold time and release gap.
module keypad_emulator #(
    parameter int HOLD_CYCLES = 4194304,
    parameter int GAP_CYCLES  = 4194304
) (
    input  logic               clk_i,
    input  logic               rst_i,
    keypad_emulator_if.slave   cmd,
    input  logic [3:0]         col_i,
    output logic [3:0]         row_o,
    output logic               pressing_o,
    output logic               busy_o,
    output logic [2:0]         fifo_count_o
);

    localparam int MAX_C = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cur_q, cur_d;
    logic [3:0]    row_q, row_d;

    logic [3:0]    mem_q [4];
    logic [1:0]    wr_ptr_q, wr_ptr_d;
    logic [1:0]    rd_ptr_q, rd_ptr_d;
    logic [2:0]    count_q, count_d;

    logic          push;
    logic          pop;

    // Ready ignores pop so a full FIFO never takes a push in the pop cycle.
    assign cmd.cmd_ready = !rst_i && (count_q < 3'd4);
    assign push          = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd.cmd_pos;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != 3'd0) begin
                    pop     = 1'b1;
                    cur_d   = mem_q[rd_ptr_q];
                    cnt_d   = HOLD_LD;
                    state_d = S_PRESS;
                end
            end
            S_PRESS: begin
                if (cnt_q == '0) begin
                    cnt_d   = GAP_LD;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Only the queued key's column is watched; other strobes are ignored.
    always_comb begin
        row_d = 4'hF;
        if (state_q == S_PRESS && !col_i[cur_q[3:2]]) begin
            row_d = ~(4'b0001 << cur_q[1:0]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cur_q   <= 4'd0;
            row_q   <= 4'hF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            row_q   <= row_d;
        end
    end

    assign row_o        = row_q;
    assign pressing_o   = (state_q == S_PRESS);
    assign busy_o       = (state_q != S_IDLE) || (count_q != 3'd0);
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with HOLD_CYCLES=8, GAP_CYCLES=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_keypad_emulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col;
    logic [3:0] row;
    logic       pressing;
    logic       busy;
    logic [2:0] fcnt;

    int vecs = 0;
    int errs = 0;

    logic [3:0] RT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    keypad_emulator_if kif ();

    keypad_emulator #(
        .HOLD_CYCLES (8),
        .GAP_CYCLES  (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd          (kif),
        .col_i        (col),
        .row_o        (row),
        .pressing_o   (pressing),
        .busy_o       (busy),
        .fifo_count_o (fcnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] p);
        int n = 0;
        kif.cmd_valid = 1'b1;
        kif.cmd_pos   = p;
        while (!kif.cmd_ready && n < 200) begin
            tick();
            n++;
        end
        vecs++;
        if (!kif.cmd_ready) begin
            errs++;
            $display("FAIL push_timeout: ready %b want 1", kif.cmd_ready);
        end
        tick();
        kif.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        vecs++;
        if (busy) begin
            errs++;
            $display("FAIL idle_timeout: busy %b want 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        kif.cmd_valid = 1'b0;
        kif.cmd_pos = 4'h0;
        col = 4'hF;
        #2;
        vecs++;
        if (row !== 4'hF) begin
            errs++; $display("FAIL rst_row: got %h want f", row);
        end
        vecs++;
        if (kif.cmd_ready !== 1'b0) begin
            errs++; $display("FAIL rst_ready: got %b want 0", kif.cmd_ready);
        end
        vecs++;
        if (pressing !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL rst_flags: press %b busy %b want 0 0", pressing, busy);
        end
        vecs++;
        if (fcnt !== 3'd0) begin
            errs++; $display("FAIL rst_count: got %0d want 0", fcnt);
        end
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
        vecs++;
        if (kif.cmd_ready !== 1'b1) begin
            errs++; $display("FAIL rst_rel_ready: got %b want 1", kif.cmd_ready);
        end
    endtask

    task automatic test_single_key();
        logic       ep;
        logic       eb;
        logic [3:0] er;
        col = 4'b1101;
        push(4'b0110);
        vecs++;
        if (pressing !== 1'b0 || fcnt !== 3'd1) begin
            errs++;
            $display("FAIL single_e0: press %b cnt %0d want 0 1", pressing, fcnt);
        end
        for (int k = 1; k <= 14; k++) begin
            tick();
            ep = (k >= 1 && k <= 8);
            er = (k >= 2 && k <= 9) ? 4'b1011 : 4'hF;
            eb = (k <= 12);
            vecs++;
            if (pressing !== ep) begin
                errs++;
                $display("FAIL single_press k=%0d: got %b want %b", k, pressing, ep);
            end
            vecs++;
            if (row !== er) begin
                errs++;
                $display("FAIL single_row k=%0d: got %b want %b", k, row, er);
            end
            vecs++;
            if (busy !== eb) begin
                errs++;
                $display("FAIL single_busy k=%0d: got %b want %b", k, busy, eb);
            end
        end
        wait_idle();
    endtask

    task automatic test_col_scan();
        logic [3:0] rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] er;
        col = 4'hF;
        push(4'b1100);
        for (int k = 1; k <= 14; k++) begin
            col = rot[k % 4];
            tick();
            er = (k - 1 >= 1 && k - 1 <= 8 && rot[k % 4] == 4'b0111) ? 4'b1110 : 4'hF;
            vecs++;
            if (row !== er) begin
                errs++;
                $display("FAIL scan_row k=%0d: got %b want %b", k, row, er);
            end
        end
        wait_idle();
    endtask

    task automatic test_multi_col();
        logic [3:0] c;
        logic [3:0] er;
        col = 4'b0000;
        push(4'b1011);
        for (int k = 1; k <= 13; k++) begin
            tick();
            er = (k >= 2 && k <= 9) ? 4'b0111 : 4'hF;
            vecs++;
            if (row !== er) begin
                errs++;
                $display("FAIL multi_all k=%0d: got %b want %b", k, row, er);
            end
        end
        wait_idle();
        col = 4'b1011;
        push(4'b1011);
        for (int k = 1; k <= 13; k++) begin
            c = (k <= 5) ? 4'b1011 : 4'b1111;
            col = c;
            tick();
            er = (k - 1 >= 1 && k - 1 <= 8 && c[2] == 1'b0) ? 4'b0111 : 4'hF;
            vecs++;
            if (row !== er) begin
                errs++;
                $display("FAIL multi_one k=%0d: got %b want %b", k, row, er);
            end
        end
        wait_idle();
    endtask

    task automatic test_fifo_full();
        logic [3:0] P [6] = '{4'b0000, 4'b0101, 4'b1010, 4'b1111, 4'b0100, 4'b1001};
        logic [2:0] ecnt [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        int         idx = 0;
        int         acc6 = -1;
        int         j;
        logic       acc;
        logic       erdy;
        logic       ep;
        logic [3:0] er;
        logic [3:0] pk;
        col = 4'b0000;
        for (int k = 0; k <= 82; k++) begin
            acc = 1'b0;
            if (idx < 6) begin
                kif.cmd_valid = 1'b1;
                kif.cmd_pos = P[idx];
                acc = kif.cmd_ready;
            end
            if (k <= 15) begin
                erdy = (k <= 4) || (k == 15);
                vecs++;
                if (kif.cmd_ready !== erdy) begin
                    errs++;
                    $display("FAIL full_ready k=%0d: got %b want %b", k, kif.cmd_ready, erdy);
                end
            end
            if (acc && idx == 5) acc6 = k;
            tick();
            if (acc) idx++;
            if (idx == 6) kif.cmd_valid = 1'b0;
            if (k <= 5) begin
                vecs++;
                if (fcnt !== ecnt[k]) begin
                    errs++;
                    $display("FAIL full_count k=%0d: got %0d want %0d", k, fcnt, ecnt[k]);
                end
            end
            j = k - 1;
            ep = (j >= 0 && j < 78 && (j % 13) < 8);
            vecs++;
            if (pressing !== ep) begin
                errs++;
                $display("FAIL full_press k=%0d: got %b want %b", k, pressing, ep);
            end
            j = k - 2;
            er = 4'hF;
            if (j >= 0 && j < 78 && (j % 13) < 8) begin
                pk = P[j / 13];
                er = RT[pk[1:0]];
            end
            vecs++;
            if (row !== er) begin
                errs++;
                $display("FAIL full_row k=%0d: got %b want %b", k, row, er);
            end
        end
        vecs++;
        if (acc6 != 15) begin
            errs++;
            $display("FAIL full_sixth_accept: got edge %0d want 15", acc6);
        end
        kif.cmd_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        col = 4'b0000;
        push(4'b0001);
        kif.cmd_valid = 1'b1;
        kif.cmd_pos = 4'b0110;
        tick();
        kif.cmd_pos = 4'b1011;
        tick();
        kif.cmd_valid = 1'b0;
        vecs++;
        if (fcnt !== 3'd2 || row !== 4'b1101) begin
            errs++;
            $display("FAIL rmid_pre: cnt %0d row %b want 2 1101", fcnt, row);
        end
        tick();
        #3 rst = 1'b1;
        #1;
        vecs++;
        if (row !== 4'hF) begin
            errs++; $display("FAIL rmid_row: got %b want 1111", row);
        end
        vecs++;
        if (kif.cmd_ready !== 1'b0) begin
            errs++; $display("FAIL rmid_ready: got %b want 0", kif.cmd_ready);
        end
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
        vecs++;
        if (fcnt !== 3'd0 || pressing !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL rmid_post: cnt %0d press %b busy %b want 0 0 0", fcnt, pressing, busy);
        end
        for (int k = 1; k <= 30; k++) begin
            tick();
            vecs++;
            if (pressing !== 1'b0 || row !== 4'hF) begin
                errs++;
                $display("FAIL rmid_noplay k=%0d: press %b row %b want 0 1111", k, pressing, row);
            end
        end
    endtask

    task automatic test_push_in_gap();
        logic ep;
        col = 4'hF;
        push(4'b0000);
        for (int k = 1; k <= 16; k++) begin
            if (k == 10) begin
                kif.cmd_valid = 1'b1;
                kif.cmd_pos = 4'b0101;
            end
            tick();
            if (k == 10) kif.cmd_valid = 1'b0;
            ep = (k <= 8) || (k >= 14);
            vecs++;
            if (pressing !== ep) begin
                errs++;
                $display("FAIL gap_press k=%0d: got %b want %b", k, pressing, ep);
            end
            if (k == 10 || k == 14) begin
                vecs++;
                if (fcnt !== ((k == 10) ? 3'd1 : 3'd0)) begin
                    errs++;
                    $display("FAIL gap_count k=%0d: got %0d", k, fcnt);
                end
            end
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_col_scan();
        test_multi_col();
        test_fifo_full();
        test_reset_mid();
        test_push_in_gap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
